song_tutor: RTL
===============

Name: song_tutor

Overview:
Parametrised "follow the lights" melody trainer for the FPGA piano. A loadable melody RAM replaces a hard-wired song. For each step the block lights the LED of the expected note, waits for the player to press and then release that key, and advances. It also counts wrong presses, supports songs of variable length, and can loop. It sits between the key-scan/debounce stage, which supplies `note`, and the board LEDs.

Parameters:
NOTE_W, 4, width of a note code; code NONE_CODE means no key pressed
LED_W, 8, number of LEDs; note code k (1..LED_W) maps to Led bit k-1
ADDR_W, 6, melody RAM address width; MAX_LEN = 2**ADDR_W steps
NONE_CODE, 0, note code meaning "no key pressed"
ERR_W, 8, width of the wrong-press counter

Ports:
CLK  input  1  system clock
RESET  input  1  asynchronous, active-high reset
note  input  NOTE_W  current debounced key code; NONE_CODE when idle
start  input  1  one-cycle pulse that begins a lesson; sampled in IDLE only
abort  input  1  level; returns the block to IDLE
loop  input  1  1 = wrap to step 0 after the last step; sampled at each wrap decision
song_len  input  ADDR_W+1  number of steps, 1..MAX_LEN; latched on an accepted start
wr_en  input  1  melody RAM write strobe; honoured in IDLE only
wr_addr  input  ADDR_W  melody RAM write address
wr_note  input  NOTE_W  melody RAM write data
Led  output  LED_W  registered LED drive
busy  output  1  1 in any state other than IDLE
done  output  1  one-cycle pulse when the last step is released
position  output  ADDR_W  index of the current step
expected  output  NOTE_W  note code of the current step
err_count  output  ERR_W  wrong presses since the last accepted start; saturating

Behaviour:
- Reset (asynchronous): state=IDLE; Led, busy, done, position, expected and err_count all 0. RAM contents are not reset.
- RAM: MAX_LEN x NOTE_W, synchronous write, synchronous read with 1-cycle latency. Writes are ignored outside IDLE.
- decode(n): one-hot bit n-1 if 1<=n<=LED_W; otherwise 0. The note is still matched even when decode gives 0.
- IDLE: Led=0, busy=0.
  - start=1 and song_len!=0: latch len = min(song_len, MAX_LEN); position=0; err_count=0; go to FETCH.
  - start=1 and song_len=0: ignored.
- FETCH (1 cycle): RAM read of `position`; expected loaded at the end of the cycle; Led=0; next state ARM.
- ARM: Led=decode(expected). Waits for note==NONE_CODE, so a key held over from an earlier step or from start cannot score; then goes to PROMPT.
- PROMPT: Led=decode(expected).
  - note==expected: go to HELD.
  - note not NONE_CODE and not expected: err_count+1 (saturates at 2**ERR_W-1); go to WRONG.
- WRONG: Led = all ones. Waits for note==NONE_CODE, then goes to PROMPT. Exactly one error is counted per wrong press, however long the key is held.
- HELD: Led=decode(expected). Changing to another key while held is neither an error nor an advance.
  - note==NONE_CODE and position!=len-1: position+1; go to FETCH.
  - note==NONE_CODE and position==len-1: done=1 for exactly 1 cycle. Then if loop=1: position=0, go to FETCH (err_count retained). If loop=0: go to IDLE.
- Led, busy and position are registered. The Led value for a state appears the cycle after that state is entered.
- abort=1 in any non-IDLE state: next state IDLE, Led=0, busy=0, no done pulse. position and err_count hold their values for readout. abort has priority over every other transition.
- start while busy: ignored.
- wr_en while busy: ignored.
- RESET asserted mid-lesson: immediate return to the reset values. The song must be restarted.
- Latency: from key release in HELD, the next step's LED is valid 3 cycles later (HELD->FETCH->ARM plus the registered Led).

Test Plan:
- Load E,E,F,G (codes 3,3,4,5) at addresses 0-3; song_len=4; loop=0; play 3,0,3,0,4,0,5,0 with each held 4 cycles -> Led sequence 0x04,0x04,0x08,0x10; done pulses once after the final release; busy=0; err_count=0.
- Same song; press 5 in place of the first 3, hold 10 cycles, release, then play correctly -> Led=0xFF while the wrong key is held; err_count=1 (not 10); the lesson completes normally.
- loop=1, song_len=2 (notes 1,2); play 1,0,2,0,1,0 -> done pulses after step 1; position returns to 0; Led=0x01 again; busy stays 1.
- Hold key 3 across the start pulse -> no advance until the key is released and pressed again; err_count=0.
- Mid-lesson abort at position 2 -> IDLE next cycle; Led=0; position=2 held; no done. Then pulse RESET during a lesson -> all outputs 0 immediately.
- Edge cases:
  - song_len=0 with start -> busy stays 0.
  - song_len=MAX_LEN+1 -> clamped to MAX_LEN.
  - wr_en while busy -> RAM unchanged.
  - 300 wrong presses -> err_count=255.

Source files
------------

// File: rtl/song_tutor.sv
// Follow-the-lights melody trainer: lights the expected note from a loadable
// melody RAM, waits for a press and release of that key, counts wrong presses.
module song_tutor #(
  parameter int unsigned NOTE_W    = 4,
  parameter int unsigned LED_W     = 8,
  parameter int unsigned ADDR_W    = 6,
  parameter int unsigned NONE_CODE = 0,
  parameter int unsigned ERR_W     = 8
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [NOTE_W-1:0] note,
  input  logic              start,
  input  logic              abort,
  input  logic              loop,
  input  logic [ADDR_W:0]   song_len,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [NOTE_W-1:0] wr_note,
  output logic [LED_W-1:0]  Led,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] position,
  output logic [NOTE_W-1:0] expected,
  output logic [ERR_W-1:0]  err_count
);

  localparam int unsigned MAX_LEN = 1 << ADDR_W;
  localparam logic [ADDR_W:0] MAX_LEN_L = (ADDR_W+1)'(MAX_LEN);

  typedef enum logic [2:0] {IDLE, FETCH, ARM, PROMPT, WRONG, HELD} state_t;

  state_t state, state_next;

  logic [NOTE_W-1:0] mem [MAX_LEN];
  logic [ADDR_W:0]   len;
  logic              none_c;
  logic              last_c;
  logic              accept_c;

  function automatic logic [LED_W-1:0] decode(input logic [NOTE_W-1:0] n);
    logic [LED_W-1:0] d;
    d = '0;
    for (int k = 1; k <= int'(LED_W); k++) begin
      if (n == NOTE_W'(k)) d[k-1] = 1'b1;
    end
    return d;
  endfunction

  assign none_c   = (note == NOTE_W'(NONE_CODE));
  assign last_c   = ({1'b0, position} == (len - (ADDR_W+1)'(1)));
  assign accept_c = (state == IDLE) && start && (song_len != '0);

  // Melody RAM write port; the player cannot rewrite the song mid-lesson
  always_ff @(posedge CLK) begin
    if (wr_en && (state == IDLE)) mem[wr_addr] <= wr_note;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept_c) state_next = FETCH;
      FETCH:   state_next = ARM;
      ARM:     if (none_c) state_next = PROMPT;
      PROMPT: begin
        if (note == expected) state_next = HELD;
        else if (!none_c)     state_next = WRONG;
      end
      WRONG:   if (none_c) state_next = PROMPT;
      HELD: begin
        if (none_c) begin
          if (!last_c)   state_next = FETCH;
          else if (loop) state_next = FETCH;
          else           state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
    if (abort && (state != IDLE)) state_next = IDLE;
  end

  // Registered outputs and lesson bookkeeping
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      Led       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      position  <= '0;
      expected  <= '0;
      err_count <= '0;
      len       <= '0;
    end else begin
      busy <= (state_next != IDLE);
      done <= (state == HELD) && none_c && last_c && !abort;

      if (state_next == IDLE) begin
        Led <= '0;
      end else begin
        case (state)
          ARM, PROMPT, HELD: Led <= decode(expected);
          WRONG:             Led <= '1;
          default:           Led <= '0;
        endcase
      end

      if (accept_c) begin
        len       <= (song_len > MAX_LEN_L) ? MAX_LEN_L : song_len;
        position  <= '0;
        err_count <= '0;
      end

      if (state == FETCH) expected <= mem[position];

      // One error per wrong press: only the PROMPT->WRONG transition counts
      if ((state == PROMPT) && !abort && !none_c && (note != expected) &&
          (err_count != '1))
        err_count <= err_count + ERR_W'(1);

      if ((state == HELD) && !abort && none_c) begin
        if (!last_c)   position <= position + ADDR_W'(1);
        else if (loop) position <= '0;
      end
    end
  end

endmodule
